cva6_ptw_sv32_walker: RTL

//  Sv32 two-level page-table walker feeding cva6_tlb_sv32.update_i on a TLB miss.

---
 rtl/cva6_ptw_sv32_pkg.sv | 47 ++++
 rtl/cva6_ptw_pte_check.sv | 40 ++++
 rtl/cva6_ptw_sv32_walker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cva6_ptw_sv32_pkg.sv
// Sv32 page-table walker shared types and helpers.
// Used by the walker top and its PTE classifier.
package cva6_ptw_sv32_pkg;

  localparam int unsigned LVL1      = 1;
  localparam int unsigned LVL0      = 0;
  localparam int unsigned PTE_BYTES = 4;

  typedef struct packed {
    logic [21:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef enum logic [2:0] {
    IDLE,
    L1_REQ,
    L1_WAIT,
    L0_REQ,
    L0_WAIT,
    DRAIN
  } walk_state_e;

  typedef struct packed {
    logic        valid;
    logic        is_4m;
    logic [19:0] vpn;
    logic [8:0]  asid;
    pte_t        pte;
  } tlb_update_t;

  // Byte address of entry idx inside the page-table page ppn.
  function automatic logic [33:0] pte_addr(
    input logic [21:0] ppn,
    input logic [9:0]  idx
  );
    return {ppn, 12'h000} + 34'(idx) * 34'(PTE_BYTES);
  endfunction

endpackage

// File: rtl/cva6_ptw_pte_check.sv
// Combinational Sv32 PTE classifier for one walk level.
// PTW_AD_CHECK_EN: leaves with A clear, or W set and D clear, fault.
module cva6_ptw_pte_check
  import cva6_ptw_sv32_pkg::*;
(
  input  logic [31:0] pte_i,
  input  logic        level_i,
  output logic        invalid_o,
  output logic        leaf_o,
  output logic        pointer_o,
  output logic        misaligned_o,
  output logic        ad_fault_o
);

  pte_t p;
  logic unused_bits;

  assign p = pte_t'(pte_i);

  // Decode the permission bits into mutually exclusive classes.
  always_comb begin
    invalid_o    = !p.v || (p.w && !p.r);
    leaf_o       = !invalid_o && (p.r || p.x);
    pointer_o    = p.v && !p.r && !p.w && !p.x;
    misaligned_o = leaf_o && (level_i == 1'(LVL1))
                   && (p.ppn[9:0] != 10'd0);
`ifdef PTW_AD_CHECK_EN
    ad_fault_o   = leaf_o && (!p.a || (p.w && !p.d));
`else
    ad_fault_o   = 1'b0;
`endif
  end

`ifdef PTW_AD_CHECK_EN
  assign unused_bits = ^{p.rsw, p.g, p.u, p.ppn[21:10]};
`else
  assign unused_bits = ^{p.rsw, p.g, p.u, p.ppn[21:10], p.a, p.d};
`endif

endmodule

// File: rtl/cva6_ptw_sv32_walker.sv
// Sv32 two-level page-table walker producing TLB updates.
// PTW_AD_CHECK_EN enables A/D-bit faults on leaf PTEs.
module cva6_ptw_sv32_walker
  import cva6_ptw_sv32_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1,
  parameter int unsigned PAW        = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [19:0]           req_vpn_i,
  input  logic [ASID_WIDTH-1:0] req_asid_i,
  output logic                  mem_req_o,
  output logic [PAW-1:0]        mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [62:0]           update_o,
  output logic                  error_o,
  output logic                  busy_o
);

  walk_state_e           state_q, state_d;
  logic [19:0]           vpn_q;
  logic [ASID_WIDTH-1:0] asid_q;
  logic [PAW-1:0]        addr_q;
  tlb_update_t           upd_q;
  logic                  err_q;

  pte_t       pte;
  logic       lvl;
  logic       in_wait;
  logic       resp_fire;
  logic       accept;
  logic       do_update;
  logic       do_ptr;
  logic       do_err;
  logic [8:0] asid_ext;

  logic invalid, leaf, pointer, misaligned, ad_fault;

  assign pte = pte_t'(mem_rdata_i);

  cva6_ptw_pte_check u_check (
    .pte_i        (mem_rdata_i),
    .level_i      (lvl),
    .invalid_o    (invalid),
    .leaf_o       (leaf),
    .pointer_o    (pointer),
    .misaligned_o (misaligned),
    .ad_fault_o   (ad_fault)
  );

  // Response decode; a flush in the rvalid cycle drops the PTE.
  always_comb begin
    lvl       = (state_q == L1_WAIT) ? 1'(LVL1) : 1'(LVL0);
    in_wait   = (state_q == L1_WAIT) || (state_q == L0_WAIT);
    resp_fire = in_wait && mem_rvalid_i && !flush_i;
    accept    = req_valid_i && req_ready_o;
    do_update = resp_fire && leaf && !misaligned && !ad_fault;
    do_ptr    = resp_fire && pointer && (lvl == 1'(LVL1));
    do_err    = resp_fire
                && (invalid || misaligned || ad_fault
                    || (pointer && (lvl == 1'(LVL0))));
    asid_ext  = '0;
    asid_ext[ASID_WIDTH-1:0] = asid_q;
  end

  // Walk state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, including flush and drain handling.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = L1_REQ;
      end
      L1_REQ, L0_REQ: begin
        if (flush_i) begin
          state_d = mem_gnt_i ? DRAIN : IDLE;
        end else if (mem_gnt_i) begin
          state_d = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
        end
      end
      L1_WAIT, L0_WAIT: begin
        if (flush_i) begin
          state_d = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          state_d = do_ptr ? L0_REQ : IDLE;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    req_ready_o = (state_q == IDLE) && !flush_i;
    mem_req_o   = (state_q == L1_REQ) || (state_q == L0_REQ);
    busy_o      = (state_q != IDLE);
    mem_addr_o  = mem_req_o ? addr_q : '0;
  end

  // Latch the miss and build each PTE address once, so it holds until grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vpn_q  <= '0;
      asid_q <= '0;
      addr_q <= '0;
    end else if (accept) begin
      vpn_q  <= req_vpn_i;
      asid_q <= req_asid_i;
      addr_q <= PAW'(pte_addr(satp_ppn_i, req_vpn_i[19:10]));
    end else if (do_ptr) begin
      addr_q <= PAW'(pte_addr(pte.ppn, vpn_q[9:0]));
    end
  end

  // Single-cycle update and fault pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upd_q <= '0;
      err_q <= 1'b0;
    end else begin
      upd_q <= '0;
      err_q <= do_err;
      if (do_update) begin
        upd_q.valid <= 1'b1;
        upd_q.is_4m <= (lvl == 1'(LVL1));
        upd_q.vpn   <= vpn_q;
        upd_q.asid  <= asid_ext;
        upd_q.pte   <= pte;
      end
    end
  end

  assign update_o = upd_q;
  assign error_o  = err_q;

endmodule
